// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C command FIFO arbiter: state encoding and
// width helpers for the grant index and the FIFO credit counter.
package i2c_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   function automatic int grant_w(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   // One extra bit so the counter can hold FIFO_DEPTH itself.
   function automatic int credit_w(input int fifo_depth);
      return $clog2(fifo_depth) + 1;
   endfunction

endpackage

// File: rtl/i2c_cmd_arbiter_rr_select.sv
// Combinational round-robin search: first set bit of req at or after ptr,
// wrapping modulo N. found is low when req is all zeros.
module rr_select #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          found
);

   always_comb begin
      logic [IW:0] cand;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         // Explicit wrap so non-power-of-two N never indexes past N-1.
         cand = {1'b0, ptr} + (IW+1)'(k);
         if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
         if (!found && req[cand[IW-1:0]]) begin
            found = 1'b1;
            idx   = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin, packet-locked arbiter sharing the I2C command FIFO write port.
// Optional idle-owner watchdog is built when ARB_WATCHDOG_EN is defined.
//
// state    | meaning
// ST_IDLE  | no owner; search for a valid requester starting at rr_ptr
// ST_GRANT | grant_id owns the FIFO until its tlast beat (or watchdog release)
module i2c_cmd_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 15,
   parameter int FIFO_DEPTH = 4,
   parameter int WDT_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          arst_n,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
   input  logic [NUM_REQ-1:0]            s_tvalid,
   input  logic [NUM_REQ-1:0]            s_tlast,
   output logic [NUM_REQ-1:0]            s_tready,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   input  logic                          fifo_rd_en,
   output logic                          grant_valid,
   output logic [grant_w(NUM_REQ)-1:0]   grant_id,
   output logic                          wdt_err
);

   localparam int GW = grant_w(NUM_REQ);
   localparam int CW = credit_w(FIFO_DEPTH);
   localparam logic [CW-1:0] CREDITS_MAX = CW'(FIFO_DEPTH);
   localparam logic [GW-1:0] LAST_ID     = GW'(NUM_REQ - 1);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("i2c_cmd_arbiter: NUM_REQ must be in 2..8");
   end
   if (WDT_CYCLES < 1) begin : g_bad_wdt_cycles
      $error("i2c_cmd_arbiter: WDT_CYCLES must be at least 1");
   end

   arb_state_t            state;
   logic [GW-1:0]         rr_ptr;
   logic [GW-1:0]         sel_idx;
   logic [GW-1:0]         next_ptr;
   logic                  sel_found;
   logic                  owner_valid;
   logic                  owner_last;
   logic                  credit_ok;
   logic                  accept;
   logic                  wdt_fire;
   logic [CW-1:0]         credits;
   logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_data[g] = s_tdata[g*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_select #(
      .N  (NUM_REQ),
      .IW (GW)
   ) u_rr_select (
      .req   (s_tvalid),
      .ptr   (rr_ptr),
      .idx   (sel_idx),
      .found (sel_found)
   );

   assign owner_valid  = s_tvalid[grant_id];
   assign owner_last   = s_tlast[grant_id];
   assign credit_ok    = (credits != '0);
   assign accept       = grant_valid && owner_valid && credit_ok;
   assign next_ptr     = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
   assign fifo_wr_en   = accept;
   assign fifo_data_in = grant_valid ? req_data[grant_id] : '0;

   always_comb begin
      s_tready = '0;
      if (grant_valid && credit_ok) s_tready[grant_id] = 1'b1;
   end

   // Credits mirror free FIFO slots; the FIFO full flag depends on wr_en and would loop.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         credits <= CREDITS_MAX;
      end else if (accept && !fifo_rd_en) begin
         credits <= credits - 1'b1;
      end else if (!accept && fifo_rd_en && credits != CREDITS_MAX) begin
         credits <= credits + 1'b1;
      end
   end

`ifdef ARB_WATCHDOG_EN
   localparam int WW = $clog2(WDT_CYCLES + 1);
   localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

   logic [WW-1:0] wdt_cnt;
   logic          stalled;

   // A credit-starved owner is not idle, so it never counts toward the timeout.
   assign stalled  = grant_valid && !owner_valid && credit_ok;
   assign wdt_fire = stalled && (wdt_cnt == WDT_LAST);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wdt_cnt <= '0;
      end else if (stalled && !wdt_fire) begin
         wdt_cnt <= wdt_cnt + 1'b1;
      end else begin
         wdt_cnt <= '0;
      end
   end
`else
   assign wdt_fire = 1'b0;
   assign wdt_err  = 1'b0;
`endif

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state       <= ST_IDLE;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         rr_ptr      <= '0;
`ifdef ARB_WATCHDOG_EN
         wdt_err     <= 1'b0;
`endif
      end else begin
`ifdef ARB_WATCHDOG_EN
         wdt_err <= wdt_fire;
`endif
         case (state)
            ST_IDLE: begin
               if (sel_found) begin
                  state       <= ST_GRANT;
                  grant_valid <= 1'b1;
                  grant_id    <= sel_idx;
               end
            end
            ST_GRANT: begin
               if ((accept && owner_last) || wdt_fire) begin
                  state       <= ST_IDLE;
                  grant_valid <= 1'b0;
                  rr_ptr      <= next_ptr;
               end
            end
            default: begin
               state       <= ST_IDLE;
               grant_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Randomized scoreboard bench for i2c_cmd_arbiter (default build, watchdog off).
module tb_i2c_cmd_arbiter;

   localparam int N   = 4;
   localparam int DW  = 15;
   localparam int FD  = 4;
   localparam int WDT = 16;
   localparam int GW  = 2;

   logic          clk = 1'b0;
   logic          arst_n;
   logic [N*DW-1:0] s_tdata;
   logic [N-1:0]  s_tvalid;
   logic [N-1:0]  s_tlast;
   logic [N-1:0]  s_tready;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_data_in;
   logic          fifo_rd_en;
   logic          grant_valid;
   logic [GW-1:0] grant_id;
   logic          wdt_err;

   i2c_cmd_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (FD),
      .WDT_CYCLES (WDT)
   ) dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tlast      (s_tlast),
      .s_tready     (s_tready),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_data_in (fifo_data_in),
      .fifo_rd_en   (fifo_rd_en),
      .grant_valid  (grant_valid),
      .grant_id     (grant_id),
      .wdt_err      (wdt_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            gv;
      int            gid;
      logic [N-1:0]  tready;
      bit            wr;
   } stat_t;

   typedef struct {
      int            id;
      logic [DW-1:0] data;
   } beat_t;

   stat_t stat_q[$];
   beat_t beat_q[$];
   int    n_chk  = 0;
   int    n_pass = 0;

   // Reference model: who owns the FIFO, where the search starts, free slots.
   int            owner;
   int            ptr;
   int            credits;
   logic [DW-1:0] cur_data [N];
   bit            cur_last [N];
   int            beat_no  [N];
   int            pkt_len  [N];
   int            vprob;
   int            rprob;
   bit            did_rst;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
   endtask

   task automatic next_beat(input int i);
      cur_data[i] = DW'($urandom);
      cur_last[i] = (beat_no[i] == pkt_len[i] - 1);
      beat_no[i]++;
   endtask

   task automatic new_packet(input int i);
      pkt_len[i] = $urandom_range(1, 6);
      beat_no[i] = 0;
      next_beat(i);
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         s_tdata[i*DW +: DW] = cur_data[i];
         s_tlast[i]          = cur_last[i];
         s_tvalid[i]         = ($urandom_range(0, 99) < vprob);
      end
      fifo_rd_en = ($urandom_range(0, 99) < rprob);
   endtask

   task automatic step_model();
      stat_t st;
      bit    acc;
      bit    found;
      int    o;
      acc       = (owner >= 0) && (credits > 0) && s_tvalid[owner];
      st.gv     = (owner >= 0);
      st.gid    = (owner >= 0) ? owner : 0;
      st.tready = ((owner >= 0) && (credits > 0)) ? (N'(1) << owner) : '0;
      st.wr     = acc;
      stat_q.push_back(st);
      if (acc) beat_q.push_back('{owner, cur_data[owner]});

      if (acc && !fifo_rd_en) credits = credits - 1;
      else if (!acc && fifo_rd_en && credits < FD) credits = credits + 1;

      if (owner < 0) begin
         found = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && s_tvalid[(ptr + k) % N]) begin
               owner = (ptr + k) % N;
               found = 1;
            end
         end
      end else if (acc) begin
         o = owner;
         if (cur_last[o]) begin
            owner = -1;
            ptr   = (o + 1) % N;
            new_packet(o);
         end else begin
            next_beat(o);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_grant_valid"}, 32'(grant_valid), 32'(0));
      check({tag, "_grant_id"}, 32'(grant_id), 32'(0));
      check({tag, "_s_tready"}, 32'(s_tready), 32'(0));
      check({tag, "_fifo_wr_en"}, 32'(fifo_wr_en), 32'(0));
      check({tag, "_fifo_data_in"}, 32'(fifo_data_in), 32'(0));
      check({tag, "_wdt_err"}, 32'(wdt_err), 32'(0));
   endtask

   // Monitor: one status entry per post-reset cycle, one beat entry per write.
   always @(negedge clk) begin
      stat_t st;
      beat_t b;
      if (arst_n) begin
         if (stat_q.size() == 0) begin
            n_chk++;
            $display("FAIL status_queue: actual empty required entry at %0t", $time);
         end else begin
            st = stat_q.pop_front();
            check("grant_valid", 32'(grant_valid), 32'(st.gv));
            if (st.gv) check("grant_id", 32'(grant_id), 32'(st.gid));
            else check("idle_fifo_data_in", 32'(fifo_data_in), 32'(0));
            check("s_tready", 32'(s_tready), 32'(st.tready));
            check("fifo_wr_en", 32'(fifo_wr_en), 32'(st.wr));
            check("wdt_err", 32'(wdt_err), 32'(0));
         end
         if (fifo_wr_en) begin
            if (beat_q.size() == 0) begin
               n_chk++;
               $display("FAIL beat_queue: actual unexpected write %0h required none at %0t",
                        fifo_data_in, $time);
            end else begin
               b = beat_q.pop_front();
               check("beat_data", 32'(fifo_data_in), 32'(b.data));
               check("beat_owner", 32'(grant_id), 32'(b.id));
            end
         end
      end
   end

   initial begin
      arst_n     = 1'b0;
      s_tvalid   = '0;
      s_tlast    = '0;
      s_tdata    = '0;
      fifo_rd_en = 1'b0;
      owner      = -1;
      ptr        = 0;
      credits    = FD;
      vprob      = 80;
      rprob      = 30;
      did_rst    = 0;
      for (int i = 0; i < N; i++) new_packet(i);

      #3;
      check_reset_outputs("por");

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc % 64 == 0) begin
            case ($urandom_range(0, 3))
               0:       rprob = 0;
               1:       rprob = 25;
               2:       rprob = 60;
               default: rprob = 100;
            endcase
            case ($urandom_range(0, 2))
               0:       vprob = 40;
               1:       vprob = 80;
               default: vprob = 100;
            endcase
         end
         if (!did_rst && cyc >= 400 && owner >= 0 && beat_no[owner] > 1) begin
            drive_inputs();
            s_tvalid = '1;
            arst_n   = 1'b0;
            #1;
            check_reset_outputs("midrst");
            owner   = -1;
            ptr     = 0;
            credits = FD;
            stat_q.delete();
            beat_q.delete();
            did_rst = 1;
         end else begin
            arst_n = 1'b1;
            drive_inputs();
            step_model();
         end
      end

      @(negedge clk);
      #1;
      check("stat_q_drained", 32'(stat_q.size()), 32'(0));
      check("beat_q_drained", 32'(beat_q.size()), 32'(0));
      check("mid_packet_reset_done", 32'(did_rst), 32'(1));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
